parity_accum_seq: RTL
=====================

Name: parity_accum_seq

Overview:
- Sequential, parametrised successor to the single-bit XOR/XNOR gate primitive.
- Accumulates bitwise XOR across a frame of WIDTH-bit words arriving on a valid/ready stream.
- Emits per-frame column parity and whole-frame parity; mode selects even (XOR) or odd (XNOR) sense.
- Sits between a word source and an error-check/compare stage in the datapath exercises.

Parameters:
- WIDTH, 8, bits per input word; min 1.
- FRAME_LEN, 4, maximum words per frame; min 1.
- CNT_W, $clog2(FRAME_LEN+1), width of the word-count output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = even/XOR sense, 1 = odd/XNOR sense; sampled on first accepted beat of a frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input word.
- in_last  in  1  marks final word of a short frame; qualified by in_valid.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts result.
- out_col  out  WIDTH  column parity: XOR of all frame words, inverted when latched mode=1.
- out_par  out  1  XOR of all bits of out_col before inversion, XOR latched mode.
- out_count  out  CNT_W  number of words in the frame (1..FRAME_LEN).

Behaviour:
- Single clock domain; reset is synchronous and active-high: on a clk edge with reset=1, all state clears.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_col=0, out_par=0, out_count=0, accumulator=0, mode latch=0.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a clk edge.
- FSM state IDLE (in_ready=1): an accepted beat loads acc=in_data, latches mode, sets cnt=1.
  - If that beat has in_last=1 or FRAME_LEN=1, go to HOLD; otherwise go to ACCUM.
- FSM state ACCUM (in_ready=1): an accepted beat does acc^=in_data and cnt+=1.
  - Go to HOLD when in_last=1 or the new cnt==FRAME_LEN.
  - in_last is ignored beyond that: a frame never exceeds FRAME_LEN words.
  - Mode changes mid-frame are ignored.
- FSM state HOLD (in_ready=0):
  - out_valid=1.
  - out_col = acc ^ {WIDTH{mode_l}}.
  - out_par = (^acc) ^ mode_l.
  - out_count = cnt.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: go to IDLE, clear acc/cnt, out_valid=0 next cycle.
- Latency: out_valid rises on the cycle after the final beat is accepted.
- Throughput: at most one frame per FRAME_LEN+1 cycles; no input is accepted during HOLD.
- Outputs are registered; out_col, out_par and out_count read 0 whenever out_valid=0.
- Idle cycles (in_valid=0) inside ACCUM keep state; there is no timeout.
- Reset mid-frame or during HOLD: the partial frame and pending result are discarded, with no out_valid pulse.
- Reset has priority over a simultaneous beat or out_ready.
- Arithmetic: cnt saturates by construction at FRAME_LEN; CNT_W is sized so FRAME_LEN is representable.

Decomposition:
- Shared package (parity_pkg) holds:
  - state encoding constants: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - mode constants: MODE_EVEN=0, MODE_ODD=1.
- One natural sub-module, xor_reduce_w: parametrised WIDTH-bit XOR reduction plus optional inversion.
  - Used for the out_par computation.
  - Reuses the gate-level XOR/XNOR idea generalised to N bits.
- FSM and accumulator stay in the top module.

Test Plan:
- All scenarios use WIDTH=8, FRAME_LEN=4.
- mode=0, words 0x01,0x02,0x04,0x08, out_ready=1 -> one cycle after 4th beat: out_valid=1, out_col=0x0F, out_par=0, out_count=4; in_ready=0 that cycle.
- Same words, mode=1 -> out_col=0xF0, out_par=1, out_count=4.
- mode=0, words 0xFF, then 0x01 with in_last=1 -> out_col=0xFE, out_par=1, out_count=2; early termination honoured.
- Backpressure: frame 0xAA,0x55,0xAA,0x55 with out_ready=0 for 5 cycles -> out_valid held, out_col=0x00, out_par=0 stable, in_ready=0 throughout; after out_ready=1, IDLE next cycle and in_ready=1.
- Reset mid-frame: accept 0x12,0x34, assert reset one cycle, then send 0x01,0x01,0x01,0x01 -> only result is out_col=0x00, out_count=4; no result for the aborted frame.
- Mode toggled mid-frame (latched 0, driven 1 from beat 2) with words 0x80,0,0,0 -> out_col=0x80, out_par=1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared encodings for the parity accumulator: FSM state values and mode sense.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/xor_reduce_w.sv
// N-bit generalisation of the XOR/XNOR gate: reduces a word to one parity bit
// and provides the word itself with the same optional inversion applied.
module xor_reduce_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_inv,
  output logic [WIDTH-1:0] o_word,
  output logic             o_par
);

  always_comb begin
    o_par = i_inv;
    for (int i = 0; i < WIDTH; i++) begin
      o_par = o_par ^ i_data[i];
    end
  end

  assign o_word = i_data ^ {WIDTH{i_inv}};

endmodule

// File: rtl/parity_accum_seq.sv
// Frame-wise column/whole parity accumulator on a valid/ready stream.
// IDLE takes the first beat, ACCUM folds the rest, HOLD presents the result.
//   state | meaning
//   IDLE  | waiting for first beat of a frame; in_ready=1
//   ACCUM | folding further beats into acc; in_ready=1
//   HOLD  | result registered on outputs until out_ready; in_ready=0
module parity_accum_seq
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_col,
  output logic             out_par,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_mode_l;
  logic             w_mode_nxt;
  logic             w_in_ready;
  logic             w_beat;
  logic             w_load_out;
  logic             w_clr_out;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_col;
  logic             r_out_par;
  logic [CNT_W-1:0] r_out_count;
  logic [WIDTH-1:0] w_col;
  logic             w_par;

  assign w_in_ready = (r_state != HOLD);
  assign w_beat     = in_valid && w_in_ready;
  assign w_cnt_inc  = r_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mode_l <= MODE_EVEN;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode_l <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode_l;
    w_load_out  = 1'b0;
    w_clr_out   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_beat) begin
          w_acc_nxt  = in_data;
          w_mode_nxt = mode;
          w_cnt_nxt  = CNT_ONE;
          if (in_last || (FRAME_LEN == 1)) begin
            w_state_nxt = HOLD;
            w_load_out  = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        // Mode is deliberately not re-sampled here; the first beat owns it.
        if (w_beat) begin
          w_acc_nxt = r_acc ^ in_data;
          w_cnt_nxt = w_cnt_inc;
          if (in_last || (w_cnt_inc == FRAME_LEN_C)) begin
            w_state_nxt = HOLD;
            w_load_out  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_clr_out   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_clr_out   = 1'b1;
      end
    endcase
  end

  // Result is computed from the next-cycle accumulator so it lands in the
  // output flops on the same edge that enters HOLD.
  xor_reduce_w #(
    .WIDTH (WIDTH)
  ) u_xor_reduce (
    .i_data (w_acc_nxt),
    .i_inv  (w_mode_nxt),
    .o_word (w_col),
    .o_par  (w_par)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_par   <= 1'b0;
      r_out_count <= '0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_col   <= w_col;
      r_out_par   <= w_par;
      r_out_count <= w_cnt_nxt;
    end else if (w_clr_out) begin
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_par   <= 1'b0;
      r_out_count <= '0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_col   = r_out_col;
  assign out_par   = r_out_par;
  assign out_count = r_out_count;

endmodule
